// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the IMEM boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    // Frame layout: little-endian word count, payload, one-byte additive checksum.
    localparam int unsigned LEN_BYTES  = 4;
    localparam int unsigned CSUM_BYTES = 1;

    // One-hot byte-lane enable for a byte offset within a 32-bit word.
    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/imem_loader_byte_writer.sv
// IMEM-facing write stage: turns one accepted payload byte into a single-cycle
// byte-lane write strobe on the following cycle.
module imem_byte_writer
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_byte,
    input  logic [ADDR_W+1:0] wr_index,
    output logic [3:0]        imem_wea,
    output logic [ADDR_W-1:0] imem_addra,
    output logic [31:0]       imem_dina
);

    // Register the strobe; all IMEM outputs return to zero on non-write cycles.
    always_ff @(posedge clk) begin
        if (rst || !wr_en) begin
            imem_wea   <= '0;
            imem_addra <= '0;
            imem_dina  <= '0;
        end else begin
            imem_wea   <= lane_mask(wr_index[1:0]);
            imem_addra <= ADDR_W'(BASE_ADDR) + wr_index[ADDR_W+1:2];
            imem_dina  <= {4{wr_byte}};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time IMEM loader: receives a length/payload/checksum frame over a
// valid/ready byte stream, writes the payload into IMEM one lane at a time and
// holds the core at its reset PC until a good image is in place.
// Optional inter-byte idle timeout: define IMEM_LOADER_TIMEOUT_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W         = 14,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [3:0]        imem_wea,
    output logic [ADDR_W-1:0] imem_addra,
    output logic [31:0]       imem_dina,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned IDX_W  = ADDR_W + 2;
    localparam int unsigned LCNT_W = $clog2(LEN_BYTES);
    localparam logic [32:0] MAX_WORDS = (33'd1 << ADDR_W) - 33'(BASE_ADDR);

    state_t state, state_nx;

    logic [LCNT_W-1:0]              len_cnt;
    logic [8*(LEN_BYTES-1)-1:0]     len_lo;
    logic [8*LEN_BYTES-1:0]         len_full;
    logic [IDX_W:0]                 len_bytes_total;
    logic [IDX_W-1:0]               byte_idx;
    logic [IDX_W-1:0]               last_idx;
    logic [8*CSUM_BYTES-1:0]        csum;
    logic                           accept;
    logic                           len_last;
    logic                           len_bad;
    logic                           data_last;
    logic                           timeout;

    // Stream handshake and frame-position decode.
    always_comb begin
        s_ready         = (state == LEN) || (state == DATA) || (state == CSUM);
        accept          = s_valid && s_ready;
        len_full        = {s_data, len_lo};
        len_last        = (len_cnt == LCNT_W'(LEN_BYTES - 1));
        len_bad         = (len_full == '0) || ({1'b0, len_full} > MAX_WORDS);
        len_bytes_total = {len_full[ADDR_W:0], 2'b00};
        data_last       = (byte_idx == last_idx);
    end

`ifdef IMEM_LOADER_TIMEOUT_EN
    logic [31:0] idle_cnt;

    // Idle counter runs only while waiting for stream bytes; any accepted byte restarts it.
    always_ff @(posedge clk) begin
        if (rst || !s_ready || accept) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end

    assign timeout = !accept && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;

    // TIMEOUT_CYCLES only matters to the timeout build; referenced here so it stays declared.
    if (TIMEOUT_CYCLES != 0) begin : g_timeout_unused
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_nx = state;
        cpu_hold = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LEN;
                end
            end
            LEN: begin
                cpu_hold = 1'b1;
                busy     = 1'b1;
                if (accept && len_last) begin
                    state_nx = len_bad ? ERR : DATA;
                end else if (timeout) begin
                    state_nx = ERR;
                end
            end
            DATA: begin
                cpu_hold = 1'b1;
                busy     = 1'b1;
                if (accept && data_last) begin
                    state_nx = CSUM;
                end else if (timeout) begin
                    state_nx = ERR;
                end
            end
            CSUM: begin
                cpu_hold = 1'b1;
                busy     = 1'b1;
                if (accept) begin
                    state_nx = (s_data == csum) ? DONE : ERR;
                end else if (timeout) begin
                    state_nx = ERR;
                end
            end
            DONE: begin
                cpu_hold = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            ERR: begin
                cpu_hold = 1'b1;
                error    = 1'b1;
                if (start) begin
                    state_nx = LEN;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Frame counters, length assembly and running checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_cnt  <= '0;
            len_lo   <= '0;
            byte_idx <= '0;
            last_idx <= '0;
            csum     <= '0;
        end else begin
            case (state)
                IDLE, ERR: begin
                    if (start) begin
                        len_cnt  <= '0;
                        len_lo   <= '0;
                        byte_idx <= '0;
                        csum     <= '0;
                    end
                end
                LEN: begin
                    if (accept) begin
                        len_cnt <= len_cnt + LCNT_W'(1);
                        len_lo  <= len_full[8*LEN_BYTES-1:8];
                        if (len_last) begin
                            last_idx <= len_bytes_total[IDX_W-1:0] - IDX_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        byte_idx <= byte_idx + IDX_W'(1);
                        csum     <= csum + s_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    imem_byte_writer #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_writer (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (accept && (state == DATA)),
        .wr_byte    (s_data),
        .wr_index   (byte_idx),
        .imem_wea   (imem_wea),
        .imem_addra (imem_addra),
        .imem_dina  (imem_dina)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of frames plus hand-written
// sequences for start-ignore, mid-load reset and stalling.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int unsigned ADDR_W    = 14;
    localparam int unsigned BASE_ADDR = 0;
`ifdef IMEM_LOADER_TIMEOUT_EN
    localparam int unsigned TMO = 100;
`else
    localparam int unsigned TMO = 1000000;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic [3:0]        imem_wea;
    logic [ADDR_W-1:0] imem_addra;
    logic [31:0]       imem_dina;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned writes_seen = 0;
    int unsigned done_cnt = 0;
    int          byte_no = 0;
    int          inject_a = -1;
    int          inject_b = -1;

    typedef struct {
        logic [3:0]        wea;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       din;
        int unsigned       due;
    } wr_t;

    typedef struct {
        int unsigned n;
        logic [7:0]  csum_delta;
        bit          gappy;
        bit          exp_len_err;
        bit          exp_csum_err;
    } vec_t;

    wr_t        sb[$];
    wr_t        mon_e;
    logic [7:0] pay[$];
    logic [7:0] fixed_pay [8];

    imem_loader #(
        .ADDR_W         (ADDR_W),
        .BASE_ADDR      (BASE_ADDR),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .imem_wea   (imem_wea),
        .imem_addra (imem_addra),
        .imem_dina  (imem_dina),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Write monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (imem_wea !== 4'b0000) begin
            writes_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got wea %b addr %0h at cycle %0d, expected no write",
                         imem_wea, imem_addra, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("write_wea", 32'(imem_wea), 32'(mon_e.wea));
                check("write_addr", 32'(imem_addra), 32'(mon_e.addr));
                check("write_data", imem_dina, mon_e.din);
                check("write_cycle", cyc, mon_e.due);
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_write: got none at cycle %0d, expected wea %b addr %0h",
                     cyc, sb[0].wea, sb[0].addr);
            void'(sb.pop_front());
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit payload, input int unsigned k, input bit gappy);
        int unsigned guard;
        if (gappy) begin
            repeat ($urandom_range(0, 2)) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                tick();
            end
        end
        s_data  = b;
        s_valid = 1'b1;
        start   = (byte_no == inject_a) || (byte_no == inject_b);
        guard   = 0;
        while (!s_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_wait: got s_ready 0 after %0d cycles, expected 1", guard);
        end else begin
            if (payload) begin
                sb.push_back('{wea: 4'b0001 << (k % 4), addr: ADDR_W'(BASE_ADDR + k / 4),
                               din: {4{b}}, due: cyc + 1});
            end
            tick();
        end
        s_valid = 1'b0;
        start   = 1'b0;
        byte_no++;
    endtask

    task automatic build_payload(input int unsigned n);
        pay.delete();
        for (int unsigned k = 0; k < 4 * n; k++) begin
            pay.push_back(k < 8 ? fixed_pay[k] : 8'($urandom));
        end
    endtask

    function automatic logic [7:0] pay_sum();
        logic [7:0] s = 8'h00;
        foreach (pay[i]) s += pay[i];
        return s;
    endfunction

    task automatic send_len(input logic [31:0] n);
        for (int unsigned i = 0; i < 4; i++) send_byte(n[8*i +: 8], 1'b0, 0, 1'b0);
    endtask

    task automatic send_payload(input int unsigned first, input int unsigned last, input bit gappy);
        for (int unsigned k = first; k <= last; k++) begin
            send_byte(pay[k], 1'b1, k, gappy);
            if (gappy && k == 3) begin
                repeat (50) begin
                    s_data = 8'($urandom);
                    tick();
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by 2ms, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[7];
        int unsigned w0;
        int unsigned d0;
        int unsigned k_to;

        fixed_pay = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        vecs[0] = '{n: 2,     csum_delta: 8'd0, gappy: 1'b0, exp_len_err: 1'b0, exp_csum_err: 1'b0};
        vecs[1] = '{n: 2,     csum_delta: 8'd1, gappy: 1'b0, exp_len_err: 1'b0, exp_csum_err: 1'b1};
        vecs[2] = '{n: 2,     csum_delta: 8'd0, gappy: 1'b0, exp_len_err: 1'b0, exp_csum_err: 1'b0};
        vecs[3] = '{n: 0,     csum_delta: 8'd0, gappy: 1'b0, exp_len_err: 1'b1, exp_csum_err: 1'b0};
        vecs[4] = '{n: 16385, csum_delta: 8'd0, gappy: 1'b0, exp_len_err: 1'b1, exp_csum_err: 1'b0};
        vecs[5] = '{n: 2,     csum_delta: 8'd0, gappy: 1'b1, exp_len_err: 1'b0, exp_csum_err: 1'b0};
        vecs[6] = '{n: 5,     csum_delta: 8'd0, gappy: 1'b0, exp_len_err: 1'b0, exp_csum_err: 1'b0};

        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_wea", 32'(imem_wea), 0);
        check("reset_addr", 32'(imem_addra), 0);
        check("reset_din", imem_dina, 0);
        check("reset_s_ready", 32'(s_ready), 0);
        check("reset_cpu_hold", 32'(cpu_hold), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_error", 32'(error), 0);

        // Table-driven frames.
        for (int i = 0; i < 7; i++) begin
            w0 = writes_seen;
            d0 = done_cnt;
            byte_no = 0;
            if (!vecs[i].exp_len_err) build_payload(vecs[i].n);
            pulse_start();
            check("start_error_clear", 32'(error), 0);
            check("start_busy", 32'(busy), 1);
            check("start_hold", 32'(cpu_hold), 1);
            send_len(vecs[i].n);
            if (vecs[i].exp_len_err) begin
                check("len_err_error", 32'(error), 1);
                check("len_err_hold", 32'(cpu_hold), 1);
                check("len_err_busy", 32'(busy), 0);
                repeat (3) tick();
                check("len_err_writes", writes_seen - w0, 0);
                continue;
            end
            send_payload(0, 4 * vecs[i].n - 1, vecs[i].gappy);
            send_byte(pay_sum() + vecs[i].csum_delta, 1'b0, 0, 1'b0);
            if (vecs[i].exp_csum_err) begin
                check("csum_err_error", 32'(error), 1);
                check("csum_err_hold", 32'(cpu_hold), 1);
                check("csum_err_done", 32'(done), 0);
                tick();
                check("csum_err_sticky", 32'(error), 1);
                check("csum_err_hold2", 32'(cpu_hold), 1);
            end else begin
                check("done_pulse", 32'(done), 1);
                check("done_hold", 32'(cpu_hold), 1);
                check("done_error", 32'(error), 0);
                tick();
                check("after_done", 32'(done), 0);
                check("release_hold", 32'(cpu_hold), 0);
                check("release_busy", 32'(busy), 0);
            end
            check("frame_writes", writes_seen - w0, 4 * vecs[i].n);
            check("frame_done_count", done_cnt - d0, vecs[i].exp_csum_err ? 0 : 1);
            check("frame_sb_empty", sb.size(), 0);
        end

        // start pulses in LEN, DATA and DONE must be ignored.
        build_payload(2);
        byte_no  = 0;
        inject_a = 1;
        inject_b = 6;
        d0 = done_cnt;
        pulse_start();
        send_len(2);
        send_payload(0, 7, 1'b0);
        send_byte(pay_sum(), 1'b0, 0, 1'b0);
        inject_a = -1;
        inject_b = -1;
        check("ignore_done", 32'(done), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ignore_start_in_done", 32'(busy), 0);
        check("ignore_hold", 32'(cpu_hold), 0);
        check("ignore_done_count", done_cnt - d0, 1);

        // Reset after the 5th payload byte.
        build_payload(2);
        byte_no = 0;
        w0 = writes_seen;
        pulse_start();
        send_len(2);
        send_payload(0, 4, 1'b0);
        rst = 1'b1; s_valid = 1'b1; s_data = 8'hAA;
        tick();
        rst = 1'b0;
        check("rst_wea", 32'(imem_wea), 0);
        check("rst_hold", 32'(cpu_hold), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_s_ready", 32'(s_ready), 0);
        check("rst_error", 32'(error), 0);
        repeat (5) tick();
        s_valid = 1'b0;
        check("rst_writes", writes_seen - w0, 5);
        check("rst_still_idle", 32'(busy), 0);

        // Stall mid-payload.
        build_payload(2);
        byte_no = 0;
        w0 = writes_seen;
        pulse_start();
        send_len(2);
        send_payload(0, 2, 1'b0);
`ifdef IMEM_LOADER_TIMEOUT_EN
        k_to = 0;
        while (!error && k_to < 300) begin
            tick();
            k_to++;
        end
        check("timeout_cycles", k_to, TMO);
        check("timeout_hold", 32'(cpu_hold), 1);
`else
        k_to = 0;
        repeat (10000) begin
            tick();
            k_to++;
        end
        check("stall_busy", 32'(busy), 1);
        check("stall_error", 32'(error), 0);
        check("stall_s_ready", 32'(s_ready), 1);
`endif
        check("stall_writes", writes_seen - w0, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("final_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
